// File: rtl/bits_pkg.sv
// Shared constants and helpers for the bit unpacker / repacker pair.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: WORD_W, CHUNK_W, LEN_W, FILL_W, ACC_W and len_mask(len) -> CHUNK_W-bit mask of the low len bits.
package bits_pkg;
    localparam int WORD_W  = 32;
    localparam int CHUNK_W = 15;
    localparam int LEN_W   = 4;
    localparam int FILL_W  = 6;
    // The accumulator must hold a 31-bit residue plus one maximal chunk.
    localparam int ACC_W   = WORD_W + CHUNK_W;

    function automatic logic [CHUNK_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [CHUNK_W-1:0] m;
        m = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            if (i < int'(len)) m[i] = 1'b1;
        end
        return m;
    endfunction
endpackage

// File: rtl/bits_pack_if.sv
// Chunk-in / word-out push bus of the repacker.
// Latency: n/a (wiring only).
// Backpressure: none; push-only in both directions.
// master drives pushin/lenin/datain/flushin and observes pushout/dataout/lenout; slave is the repacker side.
interface bits_pack_if;
    import bits_pkg::*;

    logic                 pushin;
    logic [LEN_W-1:0]     lenin;
    logic [CHUNK_W-1:0]   datain;
    logic                 flushin;
    logic                 pushout;
    logic [WORD_W-1:0]    dataout;
    logic [FILL_W-1:0]    lenout;

    modport master (
        output pushin, lenin, datain, flushin,
        input  pushout, dataout, lenout
    );

    modport slave (
        input  pushin, lenin, datain, flushin,
        output pushout, dataout, lenout
    );
endinterface

// File: rtl/bits_merge.sv
// Combinational barrel insert of a masked chunk into the accumulator at bit position fill.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: acc/fill (current state), data/len (chunk) -> acc_next (acc with chunk OR-ed in), sum (fill + len).
module bits_merge
    import bits_pkg::*;
(
    input  logic [ACC_W-1:0]   acc,
    input  logic [FILL_W-1:0]  fill,
    input  logic [CHUNK_W-1:0] data,
    input  logic [LEN_W-1:0]   len,
    output logic [ACC_W-1:0]   acc_next,
    output logic [FILL_W-1:0]  sum
);
    logic [ACC_W-1:0] ins;

    // Bits of acc at and above fill are always zero, so OR is a clean insert.
    assign ins      = {{(ACC_W-CHUNK_W){1'b0}}, data & len_mask(len)} << fill;
    assign acc_next = acc | ins;
    assign sum      = fill + {{(FILL_W-LEN_W){1'b0}}, len};
endmodule

// File: rtl/bits_pack.sv
// Repacks 0..15-bit chunks (LSB oldest) into 32-bit words; flush emits a zero-padded partial word.
// Latency: 1 cycle from the completing push (or flush) to pushout; a residue behind a full word follows 1 cycle later.
// Backpressure: none; pushout is a single-cycle pulse, dataout/lenout hold between pulses.
// Ports: clk, rst (sync, active-high), bus (bits_pack_if.slave).
module bits_pack
    import bits_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    bits_pack_if.slave   bus
);
    logic [ACC_W-1:0]  acc_q, acc_d, base_acc, merged, post_acc;
    logic [FILL_W-1:0] fill_q, fill_d, base_fill, sum, post_fill;
    logic [LEN_W-1:0]  eff_len;
    logic              pend_q, pend_d;
    logic              push_q, push_d;
    logic [WORD_W-1:0] dat_q, dat_d;
    logic [FILL_W-1:0] len_q, len_d;
    logic              full;

    // While a residue word is pending, its bits leave this cycle, so a new
    // chunk starts a fresh word at bit 0 instead of merging into the residue.
    always_comb begin
        base_acc  = pend_q ? '0 : acc_q;
        base_fill = pend_q ? '0 : fill_q;
        eff_len   = bus.pushin ? bus.lenin : '0;
    end

    bits_merge u_merge (
        .acc      (base_acc),
        .fill     (base_fill),
        .data     (bus.datain),
        .len      (eff_len),
        .acc_next (merged),
        .sum      (sum)
    );

    always_comb begin
        full      = (sum >= FILL_W'(WORD_W));
        post_acc  = full ? (merged >> WORD_W) : merged;
        post_fill = full ? (sum - FILL_W'(WORD_W)) : sum;

        acc_d  = post_acc;
        fill_d = post_fill;
        pend_d = 1'b0;
        push_d = 1'b0;
        dat_d  = dat_q;
        len_d  = len_q;

        // One output slot per cycle: a pending residue has priority, and a
        // full word can never coincide with it (fresh fill is at most 15).
        if (pend_q) begin
            push_d = 1'b1;
            dat_d  = acc_q[WORD_W-1:0];
            len_d  = fill_q;
        end else if (full) begin
            push_d = 1'b1;
            dat_d  = merged[WORD_W-1:0];
            len_d  = FILL_W'(WORD_W);
        end

        if (bus.flushin && (post_fill != '0)) begin
            if (pend_q || full) begin
                // Slot taken: keep the residue in acc and emit it next cycle.
                pend_d = 1'b1;
            end else begin
                push_d = 1'b1;
                dat_d  = post_acc[WORD_W-1:0];
                len_d  = post_fill;
                acc_d  = '0;
                fill_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            fill_q <= '0;
            pend_q <= 1'b0;
            push_q <= 1'b0;
            dat_q  <= '0;
            len_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            pend_q <= pend_d;
            push_q <= push_d;
            dat_q  <= dat_d;
            len_q  <= len_d;
        end
    end

    assign bus.pushout = push_q;
    assign bus.dataout = dat_q;
    assign bus.lenout  = len_q;
endmodule

// File: tb/tb_bits_pack.sv
// Directed and random checks of bits_pack against a bit-queue reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_bits_pack;
    import bits_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    bits_pack_if bus ();

    bits_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          l;
    } word_t;

    bit    bq[$];
    word_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_in(input logic p, input logic [3:0] len, input logic [14:0] d, input logic f);
        bus.pushin  = p;
        bus.lenin   = len;
        bus.datain  = d;
        bus.flushin = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a plain FIFO of bits; every 32 bits make a word, flush drains the rest.
    task automatic model_step(input logic p, input logic [3:0] len, input logic [14:0] d, input logic f);
        word_t w;
        if (p) begin
            for (int i = 0; i < int'(len); i++) bq.push_back(d[i]);
        end
        while (bq.size() >= 32) begin
            w.d = '0;
            for (int i = 0; i < 32; i++) w.d[i] = bq.pop_front();
            w.l = 32;
            exp_q.push_back(w);
        end
        if (f && bq.size() > 0) begin
            w.d = '0;
            w.l = bq.size();
            for (int i = 0; i < w.l; i++) w.d[i] = bq.pop_front();
            exp_q.push_back(w);
        end
    endtask

    task automatic check_out();
        word_t w;
        if (bus.pushout === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rnd_unexpected_push", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                chk("rnd_data", bus.dataout, w.d);
                chk("rnd_len", 32'(bus.lenout), 32'(w.l));
            end
        end
    endtask

    initial begin
        logic        p, f;
        logic [3:0]  len;
        logic [14:0] d;

        set_in(1'b0, 4'd0, 15'd0, 1'b0);

        // 1: reset and idle
        rst = 1'b1;
        tick();
        tick();
        chk("rst_pushout", 32'(bus.pushout), 32'd0);
        chk("rst_dataout", bus.dataout, 32'd0);
        chk("rst_lenout", 32'(bus.lenout), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_pushout", 32'(bus.pushout), 32'd0);
        set_in(1'b0, 4'd0, 15'd0, 1'b1);
        tick();
        set_in(1'b0, 4'd0, 15'd0, 1'b0);
        chk("empty_flush", 32'(bus.pushout), 32'd0);

        // 2: 8 + 15 + 9 bits make exactly one word
        set_in(1'b1, 4'd8, 15'h00AB, 1'b0);
        tick();
        chk("t2_nopush_a", 32'(bus.pushout), 32'd0);
        set_in(1'b1, 4'd15, 15'h1234, 1'b0);
        tick();
        chk("t2_nopush_b", 32'(bus.pushout), 32'd0);
        set_in(1'b1, 4'd9, 15'h01CD, 1'b0);
        tick();
        set_in(1'b0, 4'd0, 15'd0, 1'b0);
        chk("t2_push", 32'(bus.pushout), 32'd1);
        chk("t2_data", bus.dataout, {9'h1CD, 15'h1234, 8'hAB});
        chk("t2_len", 32'(bus.lenout), 32'd32);
        tick();
        chk("t2_single_pulse", 32'(bus.pushout), 32'd0);
        chk("t2_hold_data", bus.dataout, {9'h1CD, 15'h1234, 8'hAB});

        // 3: 45 ones -> full word then 13-bit flush word
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 4'd15, 15'h7FFF, 1'b0);
            tick();
        end
        set_in(1'b0, 4'd0, 15'd0, 1'b1);
        chk("t3_push", 32'(bus.pushout), 32'd1);
        chk("t3_data", bus.dataout, 32'hFFFFFFFF);
        tick();
        set_in(1'b0, 4'd0, 15'd0, 1'b0);
        chk("t3_flush_push", 32'(bus.pushout), 32'd1);
        chk("t3_flush_data", bus.dataout, 32'h00001FFF);
        chk("t3_flush_len", 32'(bus.lenout), 32'd13);
        tick();

        // 4: push+flush crossing a word boundary at fill=30
        set_in(1'b1, 4'd15, 15'h0000, 1'b0);
        tick();
        tick();
        set_in(1'b1, 4'd5, 15'h001F, 1'b1);
        tick();
        set_in(1'b1, 4'd4, 15'h0005, 1'b0);
        chk("t4_full_push", 32'(bus.pushout), 32'd1);
        chk("t4_full_data", bus.dataout, 32'hC0000000);
        chk("t4_full_len", 32'(bus.lenout), 32'd32);
        tick();
        set_in(1'b0, 4'd0, 15'd0, 1'b1);
        chk("t4_res_push", 32'(bus.pushout), 32'd1);
        chk("t4_res_data", bus.dataout, 32'h00000007);
        chk("t4_res_len", 32'(bus.lenout), 32'd3);
        tick();
        set_in(1'b0, 4'd0, 15'd0, 1'b0);
        chk("t4_fresh_push", 32'(bus.pushout), 32'd1);
        chk("t4_fresh_data", bus.dataout, 32'h00000005);
        chk("t4_fresh_len", 32'(bus.lenout), 32'd4);
        tick();
        chk("t4_quiet", 32'(bus.pushout), 32'd0);

        // 5: len0 is a no-op; bits above lenin ignored
        set_in(1'b1, 4'd3, 15'h7FFB, 1'b0);
        tick();
        set_in(1'b1, 4'd0, 15'h7FFF, 1'b0);
        tick();
        chk("t5_len0_nopush", 32'(bus.pushout), 32'd0);
        set_in(1'b0, 4'd0, 15'd0, 1'b1);
        tick();
        set_in(1'b0, 4'd0, 15'd0, 1'b0);
        chk("t5_data", bus.dataout, 32'h00000003);
        chk("t5_len", 32'(bus.lenout), 32'd3);
        tick();

        // 6: mid-stream reset discards held bits
        set_in(1'b1, 4'd15, 15'h7FFF, 1'b0);
        tick();
        set_in(1'b1, 4'd5, 15'h001F, 1'b0);
        tick();
        set_in(1'b0, 4'd0, 15'd0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_nopush", 32'(bus.pushout), 32'd0);
        set_in(1'b1, 4'd2, 15'h0003, 1'b1);
        tick();
        set_in(1'b0, 4'd0, 15'd0, 1'b0);
        chk("t6_push", 32'(bus.pushout), 32'd1);
        chk("t6_data", bus.dataout, 32'h00000003);
        chk("t6_len", 32'(bus.lenout), 32'd2);
        tick();

        // Random stream against the bit-queue model
        for (int c = 0; c < 3000; c++) begin
            p   = ($urandom_range(0, 3) != 0);
            len = 4'($urandom_range(0, 15));
            d   = 15'($urandom);
            f   = ($urandom_range(0, 15) == 0);
            set_in(p, len, d, f);
            model_step(p, len, d, f);
            tick();
            check_out();
        end
        set_in(1'b0, 4'd0, 15'd0, 1'b1);
        model_step(1'b0, 4'd0, 15'd0, 1'b1);
        tick();
        check_out();
        set_in(1'b0, 4'd0, 15'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check_out();
        end
        chk("rnd_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
